sample_delay_line: RTL

Programmable digital delay line that stores a stream of valid-qualified samples in a 16-entry circular buffer. Each sample is re-emitted exactly D accepted samples later, with D from 0 to 15. It sits directly downstream of the 4-bit wrap-around counting stage. Its write pointer advances 0..15 and wraps to 0, and on that wrap it raises a one-cycle `wrap` pulse, matching the overflow convention of the counter stage. The block produces the delayed stream for the tap/output stage.

---
 rtl/sample_delay_line.sv | 88 ++++++++
 1 files changed

// File: rtl/sample_delay_line.sv
// Programmable sample delay line: a 16-entry circular buffer that re-emits each
// accepted sample D accepted samples later (D = 0..15), with a write-pointer wrap pulse.
module sample_delay_line #(
    parameter int DATA_W        = 8,
    parameter int DEFAULT_DELAY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        delay_sel,
    input  logic              delay_load,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              primed,
    output logic [3:0]        wr_ptr,
    output logic              wrap
);

    // Valid-only stream: a sample is taken on every rising edge where in_valid=1.
    // There is no ready; the block always accepts, and out_valid is a one-cycle qualifier.
    localparam logic [3:0] LP_DEFAULT_DELAY = 4'(DEFAULT_DELAY);

    logic [DATA_W-1:0] r_mem [0:15];
    logic [3:0]        r_wr_ptr;
    logic [3:0]        r_fill;
    logic [3:0]        r_delay_q;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_wrap;

    logic [3:0]        w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_primed;

    // Read happens before this edge's write, so D=15 still sees the oldest entry.
    assign w_rd_addr = r_wr_ptr - r_delay_q;
    assign w_rd_data = r_mem[w_rd_addr];
    assign w_primed  = (r_fill >= r_delay_q);

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= 4'd0;
            r_fill      <= 4'd0;
            r_delay_q   <= LP_DEFAULT_DELAY;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_wrap      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
            if (in_valid) begin
                r_wr_ptr <= r_wr_ptr + 4'd1;
                r_wrap   <= (r_wr_ptr == 4'd15);
            end
            if (delay_load) begin
                // A coincident sample counts as the first sample of the new fill.
                r_delay_q <= delay_sel;
                r_fill    <= in_valid ? 4'd1 : 4'd0;
                if (in_valid && (delay_sel == 4'd0)) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= in_data;
                end
            end else if (in_valid) begin
                if (r_fill != 4'd15) begin
                    r_fill <= r_fill + 4'd1;
                end
                if (w_primed) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= (r_delay_q == 4'd0) ? in_data : w_rd_data;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign primed    = w_primed;
    assign wr_ptr    = r_wr_ptr;
    assign wrap      = r_wrap;

endmodule
